// File: rtl/writeback_regfile_module.sv
// rtl/writeback_regfile_module.sv - MIPS write-back stage: WB pipeline regs, 32x8 regfile, retired-write counter
// Optional write-through read bypass: define WB_BYPASS_EN.
module writeback_regfile_module #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] mux_ans_dm,
    input  logic [ADDR_W-1:0] RW_dm,
    input  logic              wb_en_dm,
    input  logic [ADDR_W-1:0] RA_id,
    input  logic [ADDR_W-1:0] RB_id,
    output logic [DATA_W-1:0] A_id,
    output logic [DATA_W-1:0] B_id,
    output logic [DATA_W-1:0] ans_wb,
    output logic [ADDR_W-1:0] RW_wb,
    output logic              wb_valid,
    output logic [CNT_W-1:0]  wb_count
);

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic [DATA_W-1:0] r_ans_wb;
    logic [ADDR_W-1:0] r_rw_wb;
    logic              r_wb_valid;
    logic [CNT_W-1:0]  r_wb_count;
    logic [DATA_W-1:0] w_a_data;
    logic [DATA_W-1:0] w_b_data;

    // r_wb_valid already excludes RW==0, so register 0 is never committed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ans_wb   <= '0;
            r_rw_wb    <= '0;
            r_wb_valid <= 1'b0;
            r_wb_count <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_ans_wb   <= mux_ans_dm;
            r_rw_wb    <= RW_dm;
            r_wb_valid <= wb_en_dm && (RW_dm != '0);
            if (r_wb_valid) begin
                r_regs[r_rw_wb] <= r_ans_wb;
                r_wb_count      <= r_wb_count + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_a_data = r_regs[RA_id];
        w_b_data = r_regs[RB_id];
`ifdef WB_BYPASS_EN
        if (r_wb_valid && (RA_id == r_rw_wb)) begin
            w_a_data = r_ans_wb;
        end
        if (r_wb_valid && (RB_id == r_rw_wb)) begin
            w_b_data = r_ans_wb;
        end
`endif
        if (RA_id == '0) begin
            w_a_data = '0;
        end
        if (RB_id == '0) begin
            w_b_data = '0;
        end
    end

    assign A_id     = w_a_data;
    assign B_id     = w_b_data;
    assign ans_wb   = r_ans_wb;
    assign RW_wb    = r_rw_wb;
    assign wb_valid = r_wb_valid;
    assign wb_count = r_wb_count;

endmodule
